// File: rtl/sap_tstate_sequencer.sv
// T-state sequencer for the SAP control unit: ring counter, halt latch and
// the datapath clock-enable, with free-run and manual single-step modes.
module sap_tstate_sequencer #(
  parameter int unsigned NUM_T_STATES = 6,
  parameter int unsigned STEP_W       = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_mode,
  input  logic                    step_req,
  input  logic                    hlt,
  input  logic                    resume,
  input  logic                    short_cycle,
  output logic                    ce,
  output logic [STEP_W-1:0]       t_idx,
  output logic [NUM_T_STATES-1:0] t_onehot,
  output logic                    halted,
  output logic                    instr_start
);

  localparam logic [STEP_W-1:0] LAST_T = STEP_W'(NUM_T_STATES - 1);

  typedef enum logic {
    RUNNING = 1'b0,
    HALTED  = 1'b1
  } run_state_e;

  run_state_e        state_q, state_d;
  logic [STEP_W-1:0] t_q, t_d;
  logic              step_req_q;
  logic              step_rise;

  // step_req_q resets high so a request held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUNNING;
      t_q        <= '0;
      step_req_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      step_req_q <= step_req;
    end
  end

  always_comb begin
    step_rise = step_req & ~step_req_q;
    ce        = (state_q == RUNNING) & (step_mode ? step_rise : 1'b1);
    state_d   = state_q;
    t_d       = t_q;
    if (ce) begin
      if (hlt) begin
        state_d = HALTED;
        t_d     = '0;
      end else if (short_cycle || (t_q >= LAST_T)) begin
        t_d = '0;
      end else begin
        t_d = t_q + STEP_W'(1);
      end
    end else if ((state_q == HALTED) && resume) begin
      // Resume only clears the latch; ce stays low for this cycle.
      state_d = RUNNING;
    end
  end

  always_comb begin
    t_onehot = '0;
    for (int unsigned i = 0; i < NUM_T_STATES; i++) begin
      t_onehot[i] = (t_q == STEP_W'(i));
    end
  end

  assign t_idx       = t_q;
  assign halted      = (state_q == HALTED);
  assign instr_start = ce & (t_q == '0);

endmodule

// File: tb/tb_sap_tstate_sequencer.sv
// Self-checking bench for sap_tstate_sequencer: directed plan steps followed by
// random control traffic, compared against an instruction-level reference model.
module tb_sap_tstate_sequencer;

  localparam int N = 6;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         step_mode, step_req, hlt, resume, short_cycle;
  logic         ce, halted, instr_start;
  logic [W-1:0] t_idx;
  logic [N-1:0] t_onehot;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: T-state number, halt latch, previous step_req level.
  int m_t;
  bit m_halted;
  bit m_prev;

  sap_tstate_sequencer #(.NUM_T_STATES(N), .STEP_W(W)) dut (
    .clk(clk), .reset(reset), .step_mode(step_mode), .step_req(step_req),
    .hlt(hlt), .resume(resume), .short_cycle(short_cycle), .ce(ce),
    .t_idx(t_idx), .t_onehot(t_onehot), .halted(halted),
    .instr_start(instr_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_vec++;
    assert (obs === 32'(expv))
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit model_ce();
    if (m_halted) return 1'b0;
    if (step_mode) return step_req && !m_prev;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_t = 0; m_halted = 1'b0; m_prev = 1'b1;
  endtask

  task automatic check_all();
    chk("ce", {31'd0, ce}, int'(model_ce()));
    chk("instr_start", {31'd0, instr_start}, int'(model_ce() && m_t == 0));
    chk("t_idx", {29'd0, t_idx}, m_t);
    chk("t_onehot", {26'd0, t_onehot}, 1 << m_t);
    chk("halted", {31'd0, halted}, int'(m_halted));
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    bit e;
    #2;
    check_all();
    e = model_ce();
    @(posedge clk);
    if (e) begin
      if (hlt) begin
        m_halted = 1'b1;
        m_t      = 0;
      end else begin
        m_t = short_cycle ? 0 : (m_t + 1) % N;
      end
    end else if (m_halted && resume) begin
      m_halted = 1'b0;
    end
    m_prev = step_req;
    #1;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (m_t != target && guard < 20) begin
      step();
      guard++;
    end
    chk("run_to_reached", {29'd0, t_idx}, target);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_t_idx", {29'd0, t_idx}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_onehot", {26'd0, t_onehot}, 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int starts;
    reset = 1'b1; step_mode = 1'b0; step_req = 1'b0;
    hlt = 1'b0; resume = 1'b0; short_cycle = 1'b0;
    model_reset();
    @(posedge clk);
    apply_reset();

    // Plan 1: free run, 14 clocks.
    starts = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (instr_start) starts++;
      step();
    end
    chk("tp1_instr_starts", 32'(starts), 3);
    chk("tp1_t_after14", {29'd0, t_idx}, 2);

    // Plan 2: short cycle at T3.
    run_to(3);
    short_cycle = 1'b1;
    step();
    short_cycle = 1'b0;
    chk("tp2_t_idx", {29'd0, t_idx}, 0);
    chk("tp2_onehot", {26'd0, t_onehot}, 1);
    chk("tp2_instr_start", {31'd0, instr_start}, 1);
    step();

    // Plan 3: halt at T4, hold 10 clocks, resume.
    run_to(4);
    hlt = 1'b1;
    step();
    hlt = 1'b0;
    chk("tp3_halted", {31'd0, halted}, 1);
    chk("tp3_t_idx", {29'd0, t_idx}, 0);
    for (int i = 0; i < 10; i++) step();
    chk("tp3_frozen", {29'd0, t_idx}, 0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("tp3_resumed", {31'd0, halted}, 0);
    chk("tp3_ce_back", {31'd0, ce}, 1);
    step();
    chk("tp3_advance", {29'd0, t_idx}, 1);

    // Plan 4: hlt and resume together while running: set wins.
    run_to(2);
    hlt = 1'b1; resume = 1'b1;
    step();
    hlt = 1'b0; resume = 1'b0;
    chk("tp4_halted", {31'd0, halted}, 1);
    chk("tp4_t_idx", {29'd0, t_idx}, 0);
    resume = 1'b1;
    step();
    resume = 1'b0;

    // Plan 5: single-step with held and repeated requests.
    step_mode = 1'b1;
    step_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    step_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    step();
    chk("tp5_two_advances", {29'd0, t_idx}, 2);
    step_req = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) step();
    chk("tp5_no_spurious", {29'd0, t_idx}, 0);
    step_req = 1'b0;
    step_mode = 1'b0;

    // Plan 6: asynchronous reset mid-cycle, running and then halted.
    run_to(3);
    #3;
    apply_reset();
    step();
    hlt = 1'b1;
    step();
    hlt = 1'b0;
    chk("tp6_halted_set", {31'd0, halted}, 1);
    #3;
    apply_reset();
    step();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      step_req    = 1'($urandom_range(0, 1));
      hlt         = ($urandom_range(0, 11) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      short_cycle = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
